// File: rtl/pkmc_ref_pkg.sv
// Shared types and defaults for the PKMC SDRAM refresh scheduler.
// Optional feature macro used by the top: PKMC_REF_URGENT_EN.
package pkmc_ref_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_GAP  = 2'b10
  } ref_state_e;

  localparam int DEF_CNT_W      = 16;
  localparam int DEF_PEND_W     = 4;
  localparam int DEF_MAX_PEND   = 8;
  localparam int INTERVAL_FLOOR = 2;

endpackage

// File: rtl/pkmc_ref_tick.sv
// Refresh interval counter: emits a one-cycle tick every effective interval.
// Intervals below the floor are raised to it; >= compare absorbs a shrinking interval.
module pkmc_ref_tick
  import pkmc_ref_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             enable,
  input  logic [CNT_W-1:0] interval,
  output logic             tick
);

  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] eff_interval_s;
  logic [CNT_W-1:0] limit_s;
  logic             tick_s;

  // Effective period and terminal-count detect
  always_comb begin
    eff_interval_s = interval;
    if (interval < CNT_W'(INTERVAL_FLOOR)) begin
      eff_interval_s = CNT_W'(INTERVAL_FLOOR);
    end else begin
      eff_interval_s = interval;
    end
    limit_s = eff_interval_s - CNT_W'(1);
    tick_s  = enable && (cnt_r >= limit_s);
  end

  // Interval counter, frozen while disabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r <= '0;
    end else if (enable) begin
      if (tick_s) begin
        cnt_r <= '0;
      end else begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  assign tick = tick_s;

endmodule

// File: rtl/pkmc_sdram_refsched.sv
// SDRAM auto-refresh scheduler: pending-refresh credit, req/ack handshake with gap, sticky overflow.
// Define PKMC_REF_URGENT_EN to drive urgent from the pending level; otherwise urgent is tied low.
module pkmc_sdram_refsched
  import pkmc_ref_pkg::*;
#(
  parameter int CNT_W     = DEF_CNT_W,
  parameter int PEND_W    = DEF_PEND_W,
  parameter int MAX_PEND  = DEF_MAX_PEND,
  parameter int GAP_CYC   = 2,
  parameter int URGENT_TH = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [CNT_W-1:0]  interval,
  input  logic              ref_ack,
  input  logic              clr_ovf,
  output logic              ref_req,
  output logic [PEND_W-1:0] pending,
  output logic              overflow,
  output logic              urgent
);

  localparam int GAP_W = (GAP_CYC > 2) ? $clog2(GAP_CYC) : 1;

  logic              tick_s;
  logic              ack_v_s;
  logic              ovf_set_s;
  logic              urgent_next_s;
  logic [PEND_W-1:0] pending_next_s;
  logic [PEND_W-1:0] pending_r;
  logic [GAP_W-1:0]  gap_r;
  ref_state_e        state_r;
  logic              ref_req_r;
  logic              overflow_r;
  logic              urgent_r;

  pkmc_ref_tick #(
    .CNT_W (CNT_W)
  ) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .interval (interval),
    .tick     (tick_s)
  );

  // Credit update; an ack only counts while a request is actually presented
  always_comb begin
    ack_v_s        = ref_ack && (state_r == ST_REQ);
    pending_next_s = pending_r;
    ovf_set_s      = 1'b0;
    if (tick_s && !ack_v_s) begin
      if (pending_r >= PEND_W'(MAX_PEND)) begin
        pending_next_s = PEND_W'(MAX_PEND);
        ovf_set_s      = 1'b1;
      end else begin
        pending_next_s = pending_r + PEND_W'(1);
        ovf_set_s      = 1'b0;
      end
    end else if (ack_v_s && !tick_s) begin
      pending_next_s = pending_r - PEND_W'(1);
    end else begin
      pending_next_s = pending_r;
    end
  end

`ifdef PKMC_REF_URGENT_EN
  assign urgent_next_s = (pending_next_s >= PEND_W'(URGENT_TH));
`else
  assign urgent_next_s = 1'b0;
`endif

  // Pending credit, sticky overflow (set beats clear) and urgent flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r  <= '0;
      overflow_r <= 1'b0;
      urgent_r   <= 1'b0;
    end else begin
      pending_r <= pending_next_s;
      urgent_r  <= urgent_next_s;
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (clr_ovf) begin
        overflow_r <= 1'b0;
      end
    end
  end

  // Handshake FSM; GAP holds ref_req low for GAP_CYC cycles after each accepted ack
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      gap_r     <= '0;
      ref_req_r <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (pending_next_s != '0) begin
            state_r   <= ST_REQ;
            ref_req_r <= 1'b1;
          end else begin
            ref_req_r <= 1'b0;
          end
        end
        ST_REQ: begin
          if (ack_v_s) begin
            state_r   <= ST_GAP;
            gap_r     <= GAP_W'(GAP_CYC - 1);
            ref_req_r <= 1'b0;
          end else begin
            ref_req_r <= 1'b1;
          end
        end
        ST_GAP: begin
          if (gap_r == '0) begin
            if (pending_next_s != '0) begin
              state_r   <= ST_REQ;
              ref_req_r <= 1'b1;
            end else begin
              state_r   <= ST_IDLE;
              ref_req_r <= 1'b0;
            end
          end else begin
            gap_r     <= gap_r - GAP_W'(1);
            ref_req_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= ST_IDLE;
          gap_r     <= '0;
          ref_req_r <= 1'b0;
        end
      endcase
    end
  end

  assign ref_req  = ref_req_r;
  assign pending  = pending_r;
  assign overflow = overflow_r;
  assign urgent   = urgent_r;

endmodule

// File: tb/tb_pkmc_sdram_refsched.sv
// Directed bench for pkmc_sdram_refsched: handshake table plus saturation, floor, shrink, reset and urgent sequences.
// Honours PKMC_REF_URGENT_EN for the expected urgent value.
module tb_pkmc_sdram_refsched;

`ifdef PKMC_REF_URGENT_EN
  localparam bit URG_EN = 1'b1;
`else
  localparam bit URG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        enable;
  logic [15:0] interval;
  logic        ref_ack;
  logic        clr_ovf;
  logic        ref_req;
  logic [3:0]  pending;
  logic        overflow;
  logic        urgent;

  int vectors = 0;
  int errors  = 0;

  typedef struct {
    logic       ack;
    logic       clr;
    logic       exp_req;
    logic [3:0] exp_pend;
    logic       exp_ovf;
  } vec_t;

  vec_t tbl [22];

  always #5 clk = ~clk;

  pkmc_sdram_refsched #(
    .CNT_W     (16),
    .PEND_W    (4),
    .MAX_PEND  (8),
    .GAP_CYC   (2),
    .URGENT_TH (6)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .interval (interval),
    .ref_ack  (ref_ack),
    .clr_ovf  (clr_ovf),
    .ref_req  (ref_req),
    .pending  (pending),
    .overflow (overflow),
    .urgent   (urgent)
  );

  task automatic chk(input string nm, input logic e_req, input logic [3:0] e_pend,
                     input logic e_ovf, input logic e_urg);
    vectors++;
    if (ref_req !== e_req || pending !== e_pend || overflow !== e_ovf || urgent !== e_urg) begin
      errors++;
      $display("FAIL %s: got req=%b pend=%0d ovf=%b urg=%b, expected req=%b pend=%0d ovf=%b urg=%b",
               nm, ref_req, pending, overflow, urgent, e_req, e_pend, e_ovf, e_urg);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input logic [15:0] iv);
    ref_ack  = 1'b0;
    clr_ovf  = 1'b0;
    enable   = 1'b1;
    interval = iv;
    rst_n    = 1'b0;
    @(negedge clk);
    chk("reset", 1'b0, 4'd0, 1'b0, 1'b0);
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1);
  end

  initial begin
    int t;
    logic [3:0] ep;

    // interval=4: ticks on edges 3,7,11,15,19
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[1]  = '{1'b0, 1'b1, 1'b0, 4'd0, 1'b0};
    tbl[2]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[3]  = '{1'b0, 1'b0, 1'b1, 4'd1, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[5]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[7]  = '{1'b0, 1'b0, 1'b1, 4'd1, 1'b0};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 4'd1, 1'b0};
    tbl[9]  = '{1'b0, 1'b0, 1'b1, 4'd1, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[11] = '{1'b0, 1'b0, 1'b0, 4'd1, 1'b0};
    tbl[12] = '{1'b1, 1'b0, 1'b1, 4'd1, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[14] = '{1'b0, 1'b0, 1'b0, 4'd0, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 1'b1, 4'd1, 1'b0};
    tbl[16] = '{1'b0, 1'b0, 1'b1, 4'd1, 1'b0};
    tbl[17] = '{1'b0, 1'b0, 1'b1, 4'd1, 1'b0};
    tbl[18] = '{1'b0, 1'b0, 1'b1, 4'd1, 1'b0};
    tbl[19] = '{1'b1, 1'b0, 1'b0, 4'd1, 1'b0};
    tbl[20] = '{1'b0, 1'b0, 1'b0, 4'd1, 1'b0};
    tbl[21] = '{1'b0, 1'b0, 1'b1, 4'd1, 1'b0};

    do_reset(16'd4);
    for (int i = 0; i < 22; i++) begin
      ref_ack = tbl[i].ack;
      clr_ovf = tbl[i].clr;
      step();
      chk($sformatf("tbl%0d", i), tbl[i].exp_req, tbl[i].exp_pend, tbl[i].exp_ovf, 1'b0);
    end
    ref_ack = 1'b0;
    clr_ovf = 1'b0;

    // Saturation and overflow: interval=10, no acks
    do_reset(16'd10);
    for (int e = 0; e < 100; e++) begin
      step();
      t  = (e + 1) / 10;
      ep = (t > 8) ? 4'd8 : 4'(t);
      chk($sformatf("sat_e%0d", e), (t >= 1), ep, (t >= 9), URG_EN && (ep >= 4'd6));
    end
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("clr_ovf", 1'b1, 4'd8, 1'b0, URG_EN);
    repeat (8) step();
    chk("ovf_stays_clear", 1'b1, 4'd8, 1'b0, URG_EN);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    chk("ovf_set_beats_clr", 1'b1, 4'd8, 1'b1, URG_EN);
    clr_ovf = 1'b1;
    step();
    clr_ovf = 1'b0;
    repeat (8) step();
    ref_ack = 1'b1;
    step();
    ref_ack = 1'b0;
    chk("tick_ack_at_max", 1'b0, 4'd8, 1'b0, URG_EN);
    step();
    chk("gap_at_max", 1'b0, 4'd8, 1'b0, URG_EN);
    step();
    chk("rereq_after_gap", 1'b1, 4'd8, 1'b0, URG_EN);

    // Interval floor: 0 and 1 both tick every 2 cycles
    for (int iv = 0; iv < 2; iv++) begin
      do_reset(16'(iv));
      for (int e = 0; e < 6; e++) begin
        step();
        chk($sformatf("floor%0d_e%0d", iv, e), (e >= 1), 4'((e + 1) / 2), 1'b0, 1'b0);
      end
    end

    // Enable low freezes the tick counter
    do_reset(16'd2);
    enable = 1'b0;
    repeat (6) step();
    chk("disabled_hold", 1'b0, 4'd0, 1'b0, 1'b0);
    enable = 1'b1;
    step();
    chk("enable_e0", 1'b0, 4'd0, 1'b0, 1'b0);
    step();
    chk("enable_e1", 1'b1, 4'd1, 1'b0, 1'b0);

    // Shrinking interval 100 -> 5 with cnt=50
    do_reset(16'd100);
    repeat (50) step();
    chk("shrink_before", 1'b0, 4'd0, 1'b0, 1'b0);
    interval = 16'd5;
    step();
    chk("shrink_tick", 1'b1, 4'd1, 1'b0, 1'b0);
    repeat (4) step();
    chk("shrink_no_tick", 1'b1, 4'd1, 1'b0, 1'b0);
    step();
    chk("shrink_next_tick", 1'b1, 4'd2, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a gap
    do_reset(16'd2);
    repeat (10) step();
    chk("pre_gap", 1'b1, 4'd5, 1'b0, 1'b0);
    ref_ack = 1'b1;
    step();
    ref_ack = 1'b0;
    chk("gap_pend4", 1'b0, 4'd4, 1'b0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", 1'b0, 4'd0, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    step();
    chk("restart_e0", 1'b0, 4'd0, 1'b0, 1'b0);
    step();
    chk("restart_e1", 1'b1, 4'd1, 1'b0, 1'b0);

    // Urgent threshold crossing and release
    do_reset(16'd2);
    for (int e = 0; e < 12; e++) begin
      step();
      if (e == 9) chk("urg_pend5", 1'b1, 4'd5, 1'b0, 1'b0);
    end
    chk("urg_pend6", 1'b1, 4'd6, 1'b0, URG_EN);
    ref_ack = 1'b1;
    step();
    ref_ack = 1'b0;
    chk("urg_release", 1'b0, 4'd5, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
